// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and CDC pointers.
// Width-parametrised conversions live in a static-only class so every user picks its own width.
package gray_pkg;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_COUNT
    } step_e;

    virtual class gray_conv #(parameter int W = 4);

        static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
            return b ^ (b >> 1);
        endfunction

        // Prefix XOR from the MSB down.
        static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
            logic [W-1:0] b;
            b[W-1] = g[W-1];
            for (int i = W - 2; i >= 0; i--) begin
                b[i] = b[i+1] ^ g[i];
            end
            return b;
        endfunction

    endclass

endpackage

// File: rtl/gray_updown_counter.sv
// Bidirectional Gray counter with synchronous load, wrap/saturate end handling,
// registered binary and Gray views, terminal-count and wrap flags.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             last_up_q;
    logic             wrap_q;
    logic             tc_q;

    logic [WIDTH-1:0] bin_nxt;
    logic             last_up_nxt;
    logic             wrap_nxt;
    logic             tc_nxt;
    step_e            step;

    always_comb begin
        if (load) begin
            step = STEP_LOAD;
        end else if (en) begin
            step = STEP_COUNT;
        end else begin
            step = STEP_HOLD;
        end
    end

    // last_up only follows up on real count edges, so tc can be registered
    // from next-state without any input reaching the output combinationally.
    always_comb begin
        bin_nxt     = bin_q;
        last_up_nxt = last_up_q;
        wrap_nxt    = 1'b0;
        case (step)
            STEP_LOAD: begin
                bin_nxt = load_bin;
            end
            STEP_COUNT: begin
                last_up_nxt = up;
                if (up) begin
                    if (bin_q == MAX_VAL) begin
                        if (!SATURATE) begin
                            bin_nxt  = '0;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        bin_nxt = bin_q + ONE;
                    end
                end else begin
                    if (bin_q == '0) begin
                        if (!SATURATE) begin
                            bin_nxt  = MAX_VAL;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        bin_nxt = bin_q - ONE;
                    end
                end
            end
            default: begin
                bin_nxt = bin_q;
            end
        endcase
        tc_nxt = last_up_nxt ? (bin_nxt == MAX_VAL) : (bin_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bin_q     <= RST_BIN;
            gray_q    <= gray_conv#(WIDTH)::bin2gray(RST_BIN);
            last_up_q <= 1'b1;
            wrap_q    <= 1'b0;
            tc_q      <= (RST_BIN == MAX_VAL);
        end else begin
            bin_q     <= bin_nxt;
            gray_q    <= gray_conv#(WIDTH)::bin2gray(bin_nxt);
            last_up_q <= last_up_nxt;
            wrap_q    <= wrap_nxt;
            tc_q      <= tc_nxt;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;
    assign wrap     = wrap_q;

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised Gray-code counter for clock-domain-crossing pointers and low-toggle position encoders.
- Counts up or down under enable.
- Supports synchronous load and wrap or saturate end-of-range handling.
- Presents registered Gray and binary views plus terminal-count and wrap flags.
- Next generation of the team's fixed-width, up-only Gray counter; drop-in for any block needing a bidirectional Gray pointer.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- SATURATE, 0, end-of-range mode: 0 = wrap modulo 2^WIDTH, 1 = hold at the end value.
- RESET_VAL, 0, binary value loaded on reset (must be < 2^WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_bin  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray code of the count.
- bin_out  output  WIDTH  registered binary count.
- tc  output  1  registered terminal count: high when count = 2^WIDTH-1 with up=1, or count = 0 with up=0.
- wrap  output  1  registered one-cycle pulse on the cycle after a wrap step.

Behaviour:
- Reset: clk and resetn are decided as stated in the Ports list.
  - On a clock edge with resetn=0: bin_out=RESET_VAL, gray_out=bin2gray(RESET_VAL), wrap=0.
  - tc is computed for RESET_VAL with up treated as 1.
  - Reset overrides load and en; a reset asserted mid-count takes effect on that edge.
- All outputs are registered. No combinational path from any input to any output.
- Priority per edge: resetn=0 > load=1 > en=1 > hold.
- Load:
  - Next bin_out = load_bin; gray_out = bin2gray(load_bin); wrap=0.
  - en and up are ignored on that edge.
- Count (en=1, load=0):
  - up=1: next = bin+1.
  - up=0: next = bin-1.
  - Arithmetic is WIDTH bits, unsigned.
- Wrap mode (SATURATE=0):
  - Max+1 → 0 and 0-1 → max.
  - wrap=1 on the following cycle only, for either direction.
- Saturate mode (SATURATE=1):
  - At max with up=1, or at 0 with up=0: the count holds.
  - wrap stays 0 always.
- Hold (en=0, load=0): count unchanged, wrap=0.
- Direction change mid-stream is legal; it takes effect on the edge where it is sampled.
- gray_out invariant: on every pure count step, exactly one bit of gray_out changes, including across a wrap.
  - Reset and load are exempt.
  - In saturate hold, no bit changes.
- tc tracks the registered count and the current up input. It is the one output with combinational dependence on up; that dependence is permitted and documented.
  - If this must be fully registered, set tc from next-state and the sampled up.
  - Decision: tc is computed from the registered count and registered last_up, where last_up resets to 1 and updates when en=1.
  - Therefore tc has no combinational input path.
- Gray state is derived from the binary state by bin2gray in the same register stage. No separate Gray adder; the two views are always consistent.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(b) = b ^ (b>>1).
  - function gray2bin(g) via prefix XOR, MSB down.
  - Both parametrised on WIDTH through a parameterised class or let-based static functions.
- No RTL sub-module required; state is a single binary register plus derived Gray, last_up, and wrap flops.
- Verification side: a reusable gray_step_checker (bench-only) asserting the one-bit-change rule, shared with future CDC FIFOs.

Test Plan:
- WIDTH=4, SATURATE=0: reset, then en=1, up=1 for 17 cycles → gray_out 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1. wrap=1 exactly on the cycle gray_out returns to 0. tc=1 while bin_out=15.
- From bin_out=0, up=0, en=1 for 2 cycles → bin_out 15 then 14, gray_out 8 then 9, wrap pulse after the first step.
- SATURATE=1: count up to 15, hold en=1, up=1 for 3 more cycles → bin_out stays 15, gray_out stays 8, wrap never asserts. Then up=0 → 14.
- load=1, en=1, load_bin=10 at bin_out=3 → next bin_out=10, gray_out=F (load wins over count), wrap=0.
- Reset mid-count at bin_out=7 with en=1, load=1 → next bin_out=RESET_VAL, gray_out=bin2gray(RESET_VAL), wrap=0. Repeat with RESET_VAL=5 → gray_out=7.
- Random en/up/load for 10k cycles, WIDTH=7 → bin_out matches a reference model and gray2bin(gray_out)==bin_out every cycle. The one-bit-change checker passes on all count steps.
